reg_cmd_ctrl: RTL and testbench

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

---
 rtl/reg_cmd_ctrl.sv | 157 +++++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: byte-serial host command front end for a 16x16 register bank.
// Optional inter-byte timeout enabled with `define REG_CMD_CTRL_TIMEOUT_EN.
module reg_cmd_ctrl #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [7:0]   cmd_data_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    output logic [7:0]   rsp_data_o,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [15:0]  reg_wdata_o,
    output logic [15:0]  reg_we_o,
    input  logic [255:0] reg_rdata_i,
    output logic         busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_RD_HI,
        S_RD_LO,
        S_RESP
    } state_t;

    localparam logic [7:0] CodeOk  = 8'hA5;
    localparam logic [7:0] CodeErr = 8'hEE;

    state_t      state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] snap_q, snap_d;
    logic [7:0]  code_q, code_d;

    logic cmd_acc;
    logic rsp_acc;
    logic wr_ok;
    logic in_cmd;
    logic in_rsp;

    // Bits 6:4 of a command byte carry no meaning.
    logic [2:0] unused_cmd_bits;
    assign unused_cmd_bits = cmd_data_i[6:4];

`ifdef REG_CMD_CTRL_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TimeoutCycles);
`endif

    assign in_cmd  = (state_q == S_IDLE) || (state_q == S_DATA_HI)
                  || (state_q == S_DATA_LO);
    assign in_rsp  = (state_q == S_RD_HI) || (state_q == S_RD_LO)
                  || (state_q == S_RESP);
    assign wr_ok   = (addr_q[3:1] != 3'b000);

    // Outputs are forced quiet while reset is held.
    assign cmd_ready_o = !rst_i && in_cmd;
    assign rsp_valid_o = !rst_i && in_rsp;
    assign busy_o      = !rst_i && (state_q != S_IDLE);
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = (!rst_i && state_q == S_WRITE && wr_ok)
                       ? (16'h0001 << addr_q) : 16'h0000;
    assign rsp_data_o  = (state_q == S_RD_HI) ? snap_q[15:8]
                       : (state_q == S_RD_LO) ? snap_q[7:0]
                       : code_q;

    assign cmd_acc = cmd_valid_i && cmd_ready_o;
    assign rsp_acc = rsp_valid_o && rsp_ready_i;

    // Next-state and datapath updates for the command FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        snap_d  = snap_q;
        code_d  = code_q;
`ifdef REG_CMD_CTRL_TIMEOUT_EN
        cnt_d   = 16'h0000;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    addr_d = cmd_data_i[3:0];
                    if (cmd_data_i[7]) begin
                        state_d = S_DATA_HI;
                    end else if (cmd_data_i[3:0] == 4'h0) begin
                        code_d  = CodeErr;
                        state_d = S_RESP;
                    end else begin
                        snap_d  = reg_rdata_i[{cmd_data_i[3:0], 4'h0} +: 16];
                        state_d = S_RD_HI;
                    end
                end
            end
            S_DATA_HI, S_DATA_LO: begin
                if (cmd_acc) begin
                    if (state_q == S_DATA_HI) begin
                        wdata_d[15:8] = cmd_data_i;
                        state_d       = S_DATA_LO;
                    end else begin
                        wdata_d[7:0] = cmd_data_i;
                        state_d      = S_WRITE;
                    end
                end
`ifdef REG_CMD_CTRL_TIMEOUT_EN
                else if (cnt_q == 16'(TimeoutCycles - 1)) begin
                    code_d  = CodeErr;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
`endif
            end
            S_WRITE: begin
                code_d  = wr_ok ? CodeOk : CodeErr;
                state_d = S_RESP;
            end
            S_RD_HI: begin
                if (rsp_acc) state_d = S_RD_LO;
            end
            S_RD_LO, S_RESP: begin
                if (rsp_acc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= 4'h0;
            wdata_q <= 16'h0000;
            snap_q  <= 16'h0000;
            code_q  <= 8'h00;
`ifdef REG_CMD_CTRL_TIMEOUT_EN
            cnt_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            snap_q  <= snap_d;
            code_q  <= code_d;
`ifdef REG_CMD_CTRL_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: directed self-checking bench for reg_cmd_ctrl.
// Vectors cover write, read, read-only error, back-pressure, reset, timeout.
module tb_reg_cmd_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [7:0]   cmd_data_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [7:0]   rsp_data_o;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [15:0]  reg_wdata_o;
    logic [15:0]  reg_we_o;
    logic [255:0] reg_rdata_i;
    logic         busy_o;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef REG_CMD_CTRL_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    reg_cmd_ctrl #(.TimeoutCycles(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to the next falling edge, then let combinational outputs settle.
    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_data_i  = 8'h00;
        rsp_ready_i = 1'b0;
        reg_rdata_i = '0;
        reg_rdata_i[5*16 +: 16] = 16'hBEEF;
        reg_rdata_i[3*16 +: 16] = 16'h1357;

        tick();
        tick();
        chk("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("rst_rspv", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_we", {16'd0, reg_we_o}, 32'd0);
        chk("rst_wdata", {16'd0, reg_wdata_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("idle_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Write 0x1234 to address 2
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h82;
        tick();
        chk("wr_hi_busy", {31'd0, busy_o}, 32'd1);
        chk("wr_hi_we", {16'd0, reg_we_o}, 32'd0);
        cmd_data_i = 8'h12;
        tick();
        cmd_data_i = 8'h34;
        tick();
        cmd_valid_i = 1'b0;
        #1;
        chk("wr_we", {16'd0, reg_we_o}, 32'h0004);
        chk("wr_wdata", {16'd0, reg_wdata_o}, 32'h1234);
        chk("wr_ready", {30'd0, cmd_ready_o, rsp_valid_o}, 32'd0);
        tick();
        chk("wr_we_off", {16'd0, reg_we_o}, 32'd0);
        chk("wr_rsp", {23'd0, rsp_valid_o, rsp_data_o}, 32'h1A5);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        #1;
        chk("wr_idle", {30'd0, busy_o, rsp_valid_o}, 32'd0);
        chk("wr_hold", {16'd0, reg_wdata_o}, 32'h1234);

        // Read address 5, source word changes after the accept cycle
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h05;
        tick();
        cmd_valid_i = 1'b0;
        reg_rdata_i[5*16 +: 16] = 16'h0000;
        #1;
        chk("rd_hi", {23'd0, rsp_valid_o, rsp_data_o}, 32'h1BE);
        rsp_ready_i = 1'b1;
        tick();
        chk("rd_lo", {23'd0, rsp_valid_o, rsp_data_o}, 32'h1EF);
        tick();
        rsp_ready_i = 1'b0;
        #1;
        chk("rd_idle", {30'd0, busy_o, cmd_ready_o}, 32'd1);

        // Write to read-only address 1
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h81;
        tick();
        cmd_data_i = 8'hFF;
        tick();
        tick();
        cmd_valid_i = 1'b0;
        #1;
        chk("ro_we", {16'd0, reg_we_o}, 32'd0);
        tick();
        chk("ro_we2", {16'd0, reg_we_o}, 32'd0);
        chk("ro_rsp", {23'd0, rsp_valid_o, rsp_data_o}, 32'h1EE);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Read address 0 gives a single error byte
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h00;
        tick();
        cmd_valid_i = 1'b0;
        #1;
        chk("r0_rsp", {23'd0, rsp_valid_o, rsp_data_o}, 32'h1EE);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        #1;
        chk("r0_idle", {30'd0, busy_o, rsp_valid_o}, 32'd0);

        // Read address 3 with response back-pressure and a pending command
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h03;
        tick();
        cmd_data_i = 8'h85;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {22'd0, rsp_valid_o, cmd_ready_o, rsp_data_o},
                32'h213);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        chk("bp_lo", {22'd0, rsp_valid_o, cmd_ready_o, rsp_data_o}, 32'h257);
        tick();
        rsp_ready_i = 1'b0;
        #1;
        chk("b2b_ready", {30'd0, busy_o, cmd_ready_o}, 32'd1);

        // 0x85 accepted now; abort with reset while in DATA_LO
        tick();
        cmd_data_i = 8'hAA;
        tick();
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        cmd_valid_i = 1'b0;
        rst_i       = 1'b1;
        #1;
        chk("mid_rst", {29'd0, cmd_ready_o, busy_o, rsp_valid_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("post_rst", {31'd0, cmd_ready_o}, 32'd1);
        chk("post_rst_wd", {16'd0, reg_wdata_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_q", {15'd0, rsp_valid_o, reg_we_o}, 32'd0);
            tick();
        end

        // Stall after a write command
        cmd_valid_i = 1'b1;
        cmd_data_i  = 8'h83;
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("to_we", {16'd0, reg_we_o}, 32'd0);
            tick();
        end
        if (ToEn)
            chk("to_rsp", {22'd0, rsp_valid_o, cmd_ready_o, rsp_data_o},
                32'h2EE);
        else
            chk("to_wait", {30'd0, rsp_valid_o, cmd_ready_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
